// File: rtl/bdb_bounce_driver_pkg.sv
// Shared types for the bounce driver: operation codes, FSM states and the
// operation record used by both the RTL and the bench transaction layer.
package bdb_rtl_pkg;

  typedef enum logic [1:0] {
    nop_op   = 2'd0,
    press_op = 2'd1,
    rsv2_op  = 2'd2,
    rsv3_op  = 2'd3
  } bdb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_BOUNCE = 3'd1,
    ST_PRESS_HOLD   = 3'd2,
    ST_REL_BOUNCE   = 3'd3,
    ST_REL_HOLD     = 3'd4,
    ST_GAP          = 3'd5
  } bdb_state_e;

  typedef struct packed {
    bdb_op_e    code;
    logic [3:0] bounces;
    logic [3:0] hold;
  } bdb_op_t;

  // A hold of zero still produces one full hold unit.
  function automatic logic [3:0] eff_hold(input logic [3:0] h);
    return (h == 4'd0) ? 4'd1 : h;
  endfunction

  function automatic logic is_reserved(input bdb_op_e c);
    return (c == rsv2_op) || (c == rsv3_op);
  endfunction

endpackage

// File: rtl/bdb_bounce_driver_if.sv
// Operation handshake between the transaction producer and the bounce driver.
interface bdb_bounce_driver_if;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic [3:0] op_bounces;
  logic [3:0] op_hold;

  modport master (output op_valid, op_code, op_bounces, op_hold, input op_ready);
  modport slave  (input op_valid, op_code, op_bounces, op_hold, output op_ready);
endinterface

// File: rtl/bdb_bounce_driver_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so a load of
// L-1 yields a phase lasting exactly L cycles.
module bdb_phase_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '0);

endmodule

// File: rtl/bdb_bounce_driver.sv
// Turns button operations into a raw, contact-bouncing button waveform.
// All outputs are registered copies of values derived from the next state.
module bdb_bounce_driver
  import bdb_rtl_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 4,
  parameter int HOLD_UNIT     = 16,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  bdb_bounce_driver_if.slave   ifc,
  output logic                 btn_raw,
  output logic                 busy,
  output logic                 op_done,
  output logic [CNT_W-1:0]     op_count,
  output logic                 op_err
);

  localparam int CLB = $clog2(BOUNCE_CYCLES);
  localparam int CLH = $clog2(15 * HOLD_UNIT);
  localparam int TW  = ((CLB > CLH) ? CLB : CLH) + 1;

  bdb_state_e       state_q, state_d;
  logic [3:0]       bounces_q, bounces_d;
  logic [3:0]       hold_q, hold_d;
  logic [3:0]       pairs_q, pairs_d;
  logic             half_q, half_d;
  logic             err_q, err_d;
  logic             btn_q, btn_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  bdb_op_t          op_in;
  logic             accept;
  logic [3:0]       hold_src;
  logic [TW-1:0]    hold_val, bounce_val, tmr_val, tmr_cnt;
  logic             tmr_load, tmr_tc, tmr_next_zero;

  assign op_in      = '{code: bdb_op_e'(ifc.op_code), bounces: ifc.op_bounces, hold: ifc.op_hold};
  assign accept     = ifc.op_valid && ready_q;
  assign hold_src   = accept ? op_in.hold : hold_q;
  assign hold_val   = TW'(int'(eff_hold(hold_src)) * HOLD_UNIT - 1);
  assign bounce_val = TW'(BOUNCE_CYCLES - 1);

  bdb_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    bounces_d = bounces_q;
    hold_d    = hold_q;
    pairs_d   = pairs_q;
    half_d    = half_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_val   = bounce_val;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bounces_d = op_in.bounces;
          hold_d    = op_in.hold;
          tmr_load  = 1'b1;
          if (op_in.code == press_op) begin
            if (op_in.bounces != 4'd0) begin
              state_d = ST_PRESS_BOUNCE;
              pairs_d = op_in.bounces;
              half_d  = 1'b0;
              tmr_val = bounce_val;
            end else begin
              state_d = ST_PRESS_HOLD;
              tmr_val = hold_val;
            end
          end else begin
            state_d = ST_GAP;
            tmr_val = hold_val;
            if (is_reserved(op_in.code)) err_d = 1'b1;
          end
        end
      end
      ST_PRESS_BOUNCE, ST_REL_BOUNCE: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (!half_q) begin
            half_d  = 1'b1;
            tmr_val = bounce_val;
          end else if (pairs_q == 4'd1) begin
            half_d  = 1'b0;
            state_d = (state_q == ST_PRESS_BOUNCE) ? ST_PRESS_HOLD : ST_REL_HOLD;
            tmr_val = hold_val;
          end else begin
            pairs_d = pairs_q - 4'd1;
            half_d  = 1'b0;
            tmr_val = bounce_val;
          end
        end
      end
      ST_PRESS_HOLD: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (bounces_q != 4'd0) begin
            state_d = ST_REL_BOUNCE;
            pairs_d = bounces_q;
            half_d  = 1'b0;
            tmr_val = bounce_val;
          end else begin
            state_d = ST_REL_HOLD;
            tmr_val = hold_val;
          end
        end
      end
      ST_REL_HOLD, ST_GAP: begin
        if (tmr_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Predict the timer reaching zero so op_done lands on the final low cycle.
  assign tmr_next_zero = tmr_load ? (tmr_val == '0) : (tmr_cnt <= TW'(1));

  always_comb begin
    btn_d = 1'b0;
    case (state_d)
      ST_PRESS_BOUNCE: btn_d = ~half_d;
      ST_PRESS_HOLD:   btn_d = 1'b1;
      ST_REL_BOUNCE:   btn_d = half_d;
      default:         btn_d = 1'b0;
    endcase
    done_d  = ((state_d == ST_REL_HOLD) || (state_d == ST_GAP)) && tmr_next_zero;
    cnt_d   = done_d ? (cnt_q + CNT_W'(1)) : cnt_q;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bounces_q <= '0;
      hold_q    <= '0;
      pairs_q   <= '0;
      half_q    <= 1'b0;
      err_q     <= 1'b0;
      btn_q     <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bounces_q <= bounces_d;
      hold_q    <= hold_d;
      pairs_q   <= pairs_d;
      half_q    <= half_d;
      err_q     <= err_d;
      btn_q     <= btn_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ifc.op_ready = ready_q;
  assign btn_raw      = btn_q;
  assign busy         = busy_q;
  assign op_done      = done_q;
  assign op_count     = cnt_q;
  assign op_err       = err_q;

endmodule

// File: tb/tb_bdb_bounce_driver.sv
// Directed bench for bdb_bounce_driver: a table of operations checked cycle by
// cycle against a waveform model, plus reset-abort and counter-wrap sequences.
module tb_bdb_bounce_driver;
  import bdb_rtl_pkg::*;

  localparam int B  = 4;
  localparam int U  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_raw, busy, op_done, op_err;
  logic [CW-1:0] op_count;

  bdb_bounce_driver_if ifc ();

  bdb_bounce_driver #(.BOUNCE_CYCLES(B), .HOLD_UNIT(U), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .ifc      (ifc.slave),
    .btn_raw  (btn_raw),
    .busy     (busy),
    .op_done  (op_done),
    .op_count (op_count),
    .op_err   (op_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  typedef struct {
    int   code;
    int   n;
    int   h;
    int   exp_len;
    int   exp_high;
    logic exp_err;
    bit   keep;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_btn(input int code, input int n, input int h, input int i);
    int hh, pb, j;
    hh = (h == 0) ? 1 : h;
    pb = 2 * n * B;
    j  = i;
    if (code != 1) return 1'b0;
    if (j < pb) return ((j / B) % 2) == 0;
    j -= pb;
    if (j < hh * U) return 1'b1;
    j -= hh * U;
    if (j < pb) return ((j / B) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic run_op(input string tag, input int code, input int n, input int h,
                        input int exp_len, input int exp_high, input logic exp_err,
                        input bit keep, input int exp_wait);
    int wait_c, high, werr, done_idx;
    logic [1:0] c2;
    logic [3:0] n4, h4;
    wait_c = 0; high = 0; werr = 0; done_idx = -1;
    c2 = code[1:0]; n4 = n[3:0]; h4 = h[3:0];
    ifc.op_valid   = 1'b1;
    ifc.op_code    = c2;
    ifc.op_bounces = n4;
    ifc.op_hold    = h4;
    while (ifc.op_ready !== 1'b1 && wait_c < 1000) begin
      tick();
      wait_c++;
    end
    check({tag, " accept_wait"}, wait_c, exp_wait);
    tick();
    if (keep) begin
      // Valid stays high with junk fields while busy; none may be taken.
      ifc.op_code    = 2'd3;
      ifc.op_bounces = 4'hf;
      ifc.op_hold    = 4'h0;
    end else begin
      ifc.op_valid = 1'b0;
    end
    for (int i = 0; i < 2000; i++) begin
      if (btn_raw !== model_btn(code, n, h, i)) werr++;
      if (btn_raw === 1'b1) high++;
      if (ifc.op_ready !== 1'b0 || busy !== 1'b1) werr++;
      if (op_done === 1'b1) begin
        done_idx = i;
        break;
      end
      tick();
    end
    if (done_idx >= 0) exp_cnt = (exp_cnt + 1) % (1 << CW);
    check({tag, " done_index"}, done_idx, exp_len - 1);
    check({tag, " wave_errors"}, werr, 0);
    check({tag, " high_cycles"}, high, exp_high);
    check({tag, " op_count"}, op_count, exp_cnt);
    check({tag, " op_err"}, op_err, exp_err);
    if (!keep) begin
      tick();
      check({tag, " idle_after"}, {op_done, ifc.op_ready, busy, btn_raw}, 4'b0100);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int dones, highs;
    bit prev_keep;

    vecs[0] = '{code: 1, n: 0,  h: 1,  exp_len: 32,  exp_high: 16,  exp_err: 1'b0, keep: 1'b1};
    vecs[1] = '{code: 1, n: 2,  h: 2,  exp_len: 96,  exp_high: 48,  exp_err: 1'b0, keep: 1'b1};
    vecs[2] = '{code: 1, n: 1,  h: 0,  exp_len: 48,  exp_high: 24,  exp_err: 1'b0, keep: 1'b1};
    vecs[3] = '{code: 0, n: 0,  h: 3,  exp_len: 48,  exp_high: 0,   exp_err: 1'b0, keep: 1'b0};
    vecs[4] = '{code: 3, n: 0,  h: 0,  exp_len: 16,  exp_high: 0,   exp_err: 1'b1, keep: 1'b0};
    vecs[5] = '{code: 1, n: 15, h: 15, exp_len: 720, exp_high: 360, exp_err: 1'b1, keep: 1'b0};
    vecs[6] = '{code: 2, n: 0,  h: 1,  exp_len: 16,  exp_high: 0,   exp_err: 1'b1, keep: 1'b0};

    reset          = 1'b1;
    ifc.op_valid   = 1'b0;
    ifc.op_code    = 2'd0;
    ifc.op_bounces = 4'd0;
    ifc.op_hold    = 4'd0;
    repeat (3) tick();
    check("reset outputs", {ifc.op_ready, btn_raw, busy, op_done, op_err}, 5'b10000);
    check("reset op_count", op_count, 0);
    reset = 1'b0;
    tick();
    check("post-reset idle", {ifc.op_ready, btn_raw, busy, op_done, op_err}, 5'b10000);

    prev_keep = 1'b0;
    for (int k = 0; k < 7; k++) begin
      run_op($sformatf("vec%0d", k), vecs[k].code, vecs[k].n, vecs[k].h, vecs[k].exp_len,
             vecs[k].exp_high, vecs[k].exp_err, vecs[k].keep, prev_keep ? 1 : 0);
      prev_keep = vecs[k].keep;
    end

    // Reset in the middle of a press hold.
    ifc.op_valid   = 1'b1;
    ifc.op_code    = 2'd1;
    ifc.op_bounces = 4'd0;
    ifc.op_hold    = 4'd4;
    tick();
    ifc.op_valid = 1'b0;
    repeat (20) tick();
    check("abort pre-reset btn", btn_raw, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("abort async btn/ready/busy", {btn_raw, ifc.op_ready, busy}, 3'b010);
    repeat (2) tick();
    reset = 1'b0;
    exp_cnt = 0;
    dones = 0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (op_done === 1'b1) dones++;
      if (btn_raw === 1'b1) highs++;
    end
    check("abort no op_done", dones, 0);
    check("abort btn stays low", highs, 0);
    check("abort op_count", op_count, 0);
    check("abort ready/err", {ifc.op_ready, op_err}, 2'b10);

    // 2^CNT_W nops wrap the completed-operation counter.
    for (int k = 0; k < (1 << CW); k++)
      run_op($sformatf("nop%0d", k), 0, 0, 0, 16, 0, 1'b0, 1'b0, 0);
    check("wrap op_count", op_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bdb_bounce_driver.md
# bdb_bounce_driver

Synthesizable pin-level driver for the debounced-counter environment. Consumes button operations (opcode, bounce count, hold length) over a valid/ready handshake and produces the raw, contact-bouncing button waveform that feeds the debouncer input. The transaction generator is the producer of these operations; this block is the consumer that turns each one into cycle-accurate pin activity, so the same operation stream can run on the bench or on hardware.

## Interface
- BOUNCE_CYCLES, 4: clock cycles per bounce half-period (≥1)
- HOLD_UNIT, 16: clock cycles per hold unit (≥1)
- CNT_W, 16: width of completed-operation counter
- clk  input  1  sole clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- op_valid  input  1  operation presented
- op_ready  output  1  block can accept an operation
- op_code  input  2  bdb_op_e: 0 nop_op, 1 press_op, 2/3 reserved
- op_bounces  input  4  bounce pairs per edge (0–15)
- op_hold  input  4  stable-level length in HOLD_UNITs (0 treated as 1)
- btn_raw  output  1  raw button line to debouncer, 1 = pressed
- busy  output  1  operation in progress
- op_done  output  1  one-cycle pulse when an operation completes
- op_count  output  CNT_W  completed operations, wraps at 2^CNT_W
- op_err  output  1  sticky: reserved opcode accepted

## Operation
- Accept when op_valid && op_ready; fields captured into registers that cycle; inputs ignored otherwise.
- States: IDLE, PRESS_BOUNCE, PRESS_HOLD, REL_BOUNCE, REL_HOLD, GAP.
- IDLE: op_ready=1, busy=0, btn_raw=0. On accept: press_op → PRESS_BOUNCE (or PRESS_HOLD if bounces=0); nop_op/reserved → GAP.
- PRESS_BOUNCE: N pairs, each = btn_raw 1 for BOUNCE_CYCLES then 0 for BOUNCE_CYCLES; then PRESS_HOLD.
- PRESS_HOLD: btn_raw=1 for H·HOLD_UNIT cycles (H = max(op_hold,1)); then REL_BOUNCE (or REL_HOLD if N=0).
- REL_BOUNCE: N pairs, each = 0 for BOUNCE_CYCLES then 1 for BOUNCE_CYCLES; then REL_HOLD.
- REL_HOLD and GAP: btn_raw=0 for H·HOLD_UNIT cycles; then IDLE.
- On last cycle of REL_HOLD/GAP: op_done pulses, op_count increments (wraps to 0).
- Reserved opcode: behaves as nop_op, sets op_err (cleared only by reset).
- Reset mid-operation: abort immediately; btn_raw drops to 0 asynchronously, no op_done, op_count not incremented.

## Timing
- Reset values: op_ready=1, btn_raw=0, busy=0, op_done=0, op_count=0, op_err=0; state IDLE.
- All outputs registered. btn_raw follows the phase schedule starting the cycle after accept.
- Press duration (accept+1 through last REL_HOLD cycle): 4·N·BOUNCE_CYCLES + 2·H·HOLD_UNIT. Nop: H·HOLD_UNIT.
- op_ready=0 from the cycle after accept until the cycle after op_done; next accept no earlier than 1 cycle after op_done (one IDLE cycle minimum between operations).
- op_valid held with op_ready low: no acceptance, fields may change freely.
- Phase counter width: max(clog2(BOUNCE_CYCLES), clog2(15·HOLD_UNIT))+1; no overflow for any legal input.

## Structure
- Package bdb_rtl_pkg: bdb_op_e enum (nop_op, press_op, two reserved), bdb_state_e, operation struct {code, bounces, hold}. Shared with bench transaction conversion.
- One sub-module: bdb_phase_timer — loadable down-counter with terminal-count flag, reused for bounce half-periods and hold lengths.

## Test plan
- Reset, then press_op N=0 H=1 (BOUNCE_CYCLES=4, HOLD_UNIT=16) → btn_raw high exactly 16 cycles, low 16, op_done once, op_count=1.
- press_op N=2 H=2 → btn_raw 1010 pattern of 4-cycle halves (16 cycles), high 32, 0101 pattern (16), low 32; total 96 cycles.
- Back-to-back ops with op_valid held high → second accepted exactly 1 cycle after first op_done; op_count=2.
- op_code=3 H=0 → btn_raw stays 0 for 16 cycles, op_err=1 and stays 1 through later valid ops.
- Assert reset during PRESS_HOLD → btn_raw 0 same cycle, op_ready=1 after release, op_count unchanged at 0.
- 2^CNT_W nop ops (CNT_W=4, 16 ops) → op_count wraps to 0.
